// File: rtl/dout_change_logger.sv
// -----------------------------------------------------------------------------
// dout_change_logger
//
// Purpose:
//   Watches the 5-state output sequencer's dout1/dout0 pair and logs every
//   change of the combined 4-bit code {dout1,dout0}. Each change produces a
//   record {prev_code, new_code, dwell}, where dwell is the number of edges the
//   previous code was sampled (saturating). Records are queued in a show-ahead
//   FIFO that a trace consumer drains over a valid/ready handshake.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   dout0      in   2        sequencer output 0 (low half of code)
//   dout1      in   2        sequencer output 1 (high half of code)
//   log_en     in   1        1: changes are pushed, 0: tracked only
//   rec_ready  in   1        consumer accepts rec_data this cycle
//   rec_valid  out  1        FIFO non-empty, rec_data holds the head record
//   rec_data   out  8+CW     {prev_code, new_code, dwell} at FIFO head
//   level      out  AW+1     records currently held, 0..DEPTH
//   ovf        out  1        sticky flag: a record was dropped on a full FIFO
//   ovf_clr    in   1        synchronous clear of ovf
// -----------------------------------------------------------------------------
module dout_change_logger #(
  parameter int CW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       dout0,
  input  logic [1:0]       dout1,
  input  logic             log_en,
  input  logic             rec_ready,
  output logic             rec_valid,
  output logic [8+CW-1:0]  rec_data,
  output logic [AW:0]      level,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int            RW         = 8 + CW;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_MAX   = '1;

  logic [3:0]    in_code;
  logic [3:0]    prev;
  logic [CW-1:0] hold;
  logic          chg;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] new_rec;

  logic push_req;
  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign in_code = {dout1, dout0};
  assign chg     = (in_code != prev);
  assign new_rec = {prev, in_code, hold};

  assign full      = (level == FULL_LEVEL);
  assign rec_valid = (level != '0);
  assign rec_data  = mem[rd_ptr];

  // A push into a full FIFO still succeeds when the head is leaving on the
  // same edge; only a push with no room and no pop is dropped.
  assign push_req = chg && log_en;
  assign do_pop   = rec_valid && rec_ready;
  assign do_push  = push_req && (!full || do_pop);
  assign drop     = push_req && full && !do_pop;

  // Change tracker. The change edge itself counts as the first sample of the
  // new code, so hold restarts at 1 rather than 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 4'h0;
      hold <= '0;
    end else begin
      prev <= in_code;
      if (chg) begin
        hold <= CW'(1);
      end else if (hold != HOLD_MAX) begin
        hold <= hold + CW'(1);
      end
    end
  end

  // Record storage has no reset; its contents are only observed while
  // rec_valid is high.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a drop on the same edge as ovf_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dout_change_logger.sv
// -----------------------------------------------------------------------------
// tb_dout_change_logger
//
// Purpose:
//   Self-checking bench for dout_change_logger. Directed code sequences are
//   driven onto dout1/dout0; the hand-computed record for every logged change
//   is pushed into an expected queue, and a monitor pops and compares whenever
//   the DUT hands a record to the consumer. Status outputs (level, ovf,
//   rec_valid) are compared directly at chosen points.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_dout_change_logger;

  localparam int CW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RW    = 8 + CW;

  logic          clk;
  logic          rst_n;
  logic [1:0]    dout0;
  logic [1:0]    dout1;
  logic          log_en;
  logic          rec_ready;
  logic          rec_valid;
  logic [RW-1:0] rec_data;
  logic [AW:0]   level;
  logic          ovf;
  logic          ovf_clr;

  logic [RW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            max_level = 0;

  dout_change_logger #(.CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dout0     (dout0),
    .dout1     (dout1),
    .log_en    (log_en),
    .rec_ready (rec_ready),
    .rec_valid (rec_valid),
    .rec_data  (rec_data),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a code and lets it be sampled on n rising edges; inputs change
  // 1 ns after each edge so they are stable well before the next one.
  task automatic applyStimulus(input logic [3:0] code, input int n);
    {dout1, dout0} = code;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (int'(level) > max_level) max_level = int'(level);
    end
  endtask

  function automatic logic [RW-1:0] mkRec(input logic [3:0] p,
                                          input logic [3:0] n,
                                          input logic [CW-1:0] d);
    return {p, n, d};
  endfunction

  // Monitor: every handshake the DUT completes must match the oldest
  // outstanding expected record.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_record: got 0x%0h, expected none", rec_data);
      end else begin
        checkOutput("record", 32'(rec_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    dout0     = 2'd0;
    dout1     = 2'd0;
    log_en    = 1'b1;
    rec_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(rec_valid), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Test 1: code 0 for 5 edges then code 1
    $display("[TB] test 1: first record latency");
    applyStimulus(4'h0, 5);
    exp_q.push_back(mkRec(4'h0, 4'h1, 8'd5));
    applyStimulus(4'h1, 1);
    checkOutput("t1_valid", 32'(rec_valid), 32'd1);
    checkOutput("t1_level", 32'(level), 32'd1);
    checkOutput("t1_data", 32'(rec_data), 32'h0105);

    // Test 2: full sequencer pattern with a draining consumer
    $display("[TB] test 2: sequencer pattern");
    rec_ready = 1'b1;
    max_level = 0;
    applyStimulus(4'h1, 2);
    exp_q.push_back(mkRec(4'h1, 4'h0, 8'd3));
    applyStimulus(4'h0, 4);
    exp_q.push_back(mkRec(4'h0, 4'h5, 8'd4));
    applyStimulus(4'h5, 2);
    exp_q.push_back(mkRec(4'h5, 4'h9, 8'd2));
    applyStimulus(4'h9, 3);
    exp_q.push_back(mkRec(4'h9, 4'hA, 8'd3));
    applyStimulus(4'hA, 1);
    exp_q.push_back(mkRec(4'hA, 4'hF, 8'd1));
    applyStimulus(4'hF, 5);
    exp_q.push_back(mkRec(4'hF, 4'h0, 8'd5));
    applyStimulus(4'h0, 3);
    checkOutput("t2_max_level", 32'(max_level), 32'd1);
    checkOutput("t2_level", 32'(level), 32'd0);
    checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);

    // Test 3: ten changes into a stalled FIFO, last two dropped
    $display("[TB] test 3: overflow");
    rec_ready = 1'b0;
    exp_q.push_back(mkRec(4'h0, 4'h1, 8'd3));
    applyStimulus(4'h1, 2);
    exp_q.push_back(mkRec(4'h1, 4'h2, 8'd2));
    applyStimulus(4'h2, 2);
    exp_q.push_back(mkRec(4'h2, 4'h3, 8'd2));
    applyStimulus(4'h3, 2);
    exp_q.push_back(mkRec(4'h3, 4'h4, 8'd2));
    applyStimulus(4'h4, 2);
    exp_q.push_back(mkRec(4'h4, 4'h5, 8'd2));
    applyStimulus(4'h5, 2);
    exp_q.push_back(mkRec(4'h5, 4'h6, 8'd2));
    applyStimulus(4'h6, 2);
    exp_q.push_back(mkRec(4'h6, 4'h7, 8'd2));
    applyStimulus(4'h7, 2);
    exp_q.push_back(mkRec(4'h7, 4'h8, 8'd2));
    applyStimulus(4'h8, 2);
    checkOutput("t3_ovf_before_drop", 32'(ovf), 32'd0);
    applyStimulus(4'h9, 2);
    applyStimulus(4'hA, 2);
    checkOutput("t3_level", 32'(level), 32'd8);
    checkOutput("t3_ovf", 32'(ovf), 32'd1);
    checkOutput("t3_head", 32'(rec_data), 32'h0103);
    ovf_clr = 1'b1;
    applyStimulus(4'hA, 1);
    ovf_clr = 1'b0;
    checkOutput("t3_ovf_clr", 32'(ovf), 32'd0);

    // Test 4: full FIFO, change and pop on the same edge
    $display("[TB] test 4: push with pop on full");
    rec_ready = 1'b1;
    exp_q.push_back(mkRec(4'hA, 4'hB, 8'd3));
    applyStimulus(4'hB, 1);
    checkOutput("t4_level", 32'(level), 32'd8);
    checkOutput("t4_ovf", 32'(ovf), 32'd0);
    applyStimulus(4'hB, 9);
    checkOutput("t4_level_drained", 32'(level), 32'd0);
    checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: dwell saturation and a change with logging disabled
    $display("[TB] test 5: saturation and log_en");
    exp_q.push_back(mkRec(4'hB, 4'h3, 8'd10));
    applyStimulus(4'h3, 300);
    exp_q.push_back(mkRec(4'h3, 4'h4, 8'hFF));
    applyStimulus(4'h4, 2);
    log_en = 1'b0;
    applyStimulus(4'h5, 3);
    checkOutput("t5_no_push_level", 32'(level), 32'd0);
    checkOutput("t5_no_ovf", 32'(ovf), 32'd0);
    log_en = 1'b1;
    exp_q.push_back(mkRec(4'h5, 4'h6, 8'd3));
    applyStimulus(4'h6, 2);
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: asynchronous reset with four records queued
    $display("[TB] test 6: async reset");
    rec_ready = 1'b0;
    applyStimulus(4'h7, 1);
    applyStimulus(4'h8, 1);
    applyStimulus(4'h9, 1);
    applyStimulus(4'hA, 1);
    checkOutput("t6_level_before", 32'(level), 32'd4);
    checkOutput("t6_valid_before", 32'(rec_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid_reset", 32'(rec_valid), 32'd0);
    checkOutput("t6_level_reset", 32'(level), 32'd0);
    checkOutput("t6_ovf_reset", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rec_ready = 1'b1;
    exp_q.push_back(mkRec(4'h0, 4'hA, 8'd0));
    applyStimulus(4'hA, 3);
    checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_level_end", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
